// File: rtl/pong_match_controller_pkg.sv
// Shared widths, game-state encoding and winner codes for the pong match controller.
package pong_pkg;

   localparam int unsigned SCORE_W  = 4;
   localparam int unsigned COORD_W  = 13;
   localparam int unsigned STATE_W  = 3;
   localparam int unsigned WINNER_W = 2;
   localparam int unsigned FCNT_W   = 16;

   localparam logic [STATE_W-1:0] GS_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] GS_SERVE     = 3'd1;
   localparam logic [STATE_W-1:0] GS_PLAY      = 3'd2;
   localparam logic [STATE_W-1:0] GS_POINT     = 3'd3;
   localparam logic [STATE_W-1:0] GS_GAME_OVER = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = GS_IDLE,
      ST_SERVE     = GS_SERVE,
      ST_PLAY      = GS_PLAY,
      ST_POINT     = GS_POINT,
      ST_GAME_OVER = GS_GAME_OVER
   } game_state_e;

   localparam logic [WINNER_W-1:0] WIN_NONE  = 2'b00;
   localparam logic [WINNER_W-1:0] WIN_LEFT  = 2'b01;
   localparam logic [WINNER_W-1:0] WIN_RIGHT = 2'b10;

   // Saturating score increment; a score already at the cap stays there.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                  input logic [SCORE_W-1:0] cap);
      return (s >= cap) ? s : s + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/pong_match_controller_if.sv
// Frame/ball inputs and game status outputs of the match controller.
interface pong_match_controller_if;
   import pong_pkg::*;

   logic                newFrame;
   logic                start;
   logic                pause_sw;
   logic [COORD_W-1:0]  ball_x;
   logic                ball_pause;
   logic                ball_rst;
   logic                serve_dir;
   logic [SCORE_W-1:0]  score_l;
   logic [SCORE_W-1:0]  score_r;
   logic [STATE_W-1:0]  game_state;
   logic [WINNER_W-1:0] winner;

   modport master (
      output newFrame, start, pause_sw, ball_x,
      input  ball_pause, ball_rst, serve_dir, score_l, score_r, game_state, winner
   );

   modport slave (
      input  newFrame, start, pause_sw, ball_x,
      output ball_pause, ball_rst, serve_dir, score_l, score_r, game_state, winner
   );

endinterface

// File: rtl/pong_match_controller_frame_timer.sv
// Frame counter shared by the serve hold and post-point freeze; done fires on the terminal newFrame.
module frame_timer
   import pong_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              new_frame_i,
   input  logic [FCNT_W-1:0] term_cnt_i,
   output logic              done_c_o
);

   logic [FCNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Clear has priority so a frame arriving on the entry cycle is not counted.
   always_comb begin
      cnt_d    = cnt_q;
      done_c_o = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (new_frame_i) begin
         if (cnt_q == term_cnt_i) begin
            cnt_d    = '0;
            done_c_o = 1'b1;
         end else begin
            cnt_d = cnt_q + FCNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer: serve/play/point/game-over flow, wall-miss scoring and trajectory pause/re-centre control.
module pong_match_controller
   import pong_pkg::*;
#(
   parameter logic [COORD_W-1:0] WALL_LEFT    = COORD_W'(0),
   parameter logic [COORD_W-1:0] WALL_RIGHT   = COORD_W'(640),
   parameter int unsigned        BALL_W       = 10,
   parameter int unsigned        WIN_SCORE    = 7,
   parameter int unsigned        SERVE_FRAMES = 60,
   parameter int unsigned        POINT_FRAMES = 30
) (
   input logic                    clk,
   input logic                    reset,
   pong_match_controller_if.slave ctrl_if
);

   localparam int unsigned        EDGE_W   = COORD_W + 1;
   localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
   localparam logic [FCNT_W-1:0]  SERVE_TC = FCNT_W'(SERVE_FRAMES - 1);
   localparam logic [FCNT_W-1:0]  POINT_TC = FCNT_W'(POINT_FRAMES - 1);

   game_state_e         state_q, state_d;
   logic [SCORE_W-1:0]  score_l_q, score_l_d;
   logic [SCORE_W-1:0]  score_r_q, score_r_d;
   logic [WINNER_W-1:0] winner_q, winner_d;
   logic                ball_pause_q, ball_pause_d;
   logic                ball_rst_q, ball_rst_d;
   logic                serve_dir_q, serve_dir_d;
   logic                start_q;

   logic                start_pulse_c;
   logic                eval_c;
   logic                left_miss_c;
   logic                right_miss_c;
   logic [EDGE_W-1:0]   right_edge_c;
   logic                timer_clr_c;
   logic                timer_done_c;
   logic [FCNT_W-1:0]   timer_tc_c;

   assign start_pulse_c = ctrl_if.start & ~start_q;
   assign eval_c        = ctrl_if.newFrame & ~ctrl_if.pause_sw;
   assign right_edge_c  = {1'b0, ctrl_if.ball_x} + EDGE_W'(BALL_W);
   assign left_miss_c   = ctrl_if.ball_x <= WALL_LEFT;
   assign right_miss_c  = right_edge_c >= {1'b0, WALL_RIGHT};

   // Timer only runs while holding the serve or the post-point freeze.
   assign timer_clr_c = !((state_q == ST_SERVE) || (state_q == ST_POINT));
   assign timer_tc_c  = (state_q == ST_POINT) ? POINT_TC : SERVE_TC;

   frame_timer u_frame_timer (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (timer_clr_c),
      .new_frame_i (ctrl_if.newFrame),
      .term_cnt_i  (timer_tc_c),
      .done_c_o    (timer_done_c)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         score_l_q    <= '0;
         score_r_q    <= '0;
         winner_q     <= WIN_NONE;
         ball_pause_q <= 1'b1;
         ball_rst_q   <= 1'b0;
         serve_dir_q  <= 1'b0;
         start_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         winner_q     <= winner_d;
         ball_pause_q <= ball_pause_d;
         ball_rst_q   <= ball_rst_d;
         serve_dir_q  <= serve_dir_d;
         start_q      <= ctrl_if.start;
      end
   end

   always_comb begin
      state_d      = state_q;
      score_l_d    = score_l_q;
      score_r_d    = score_r_q;
      winner_d     = winner_q;
      serve_dir_d  = serve_dir_q;
      ball_rst_d   = 1'b0;
      ball_pause_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (start_pulse_c) begin
               state_d    = ST_SERVE;
               ball_rst_d = 1'b1;
            end
         end
         ST_SERVE: begin
            if (timer_done_c) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            // Left miss takes precedence when the ball touches both walls.
            if (eval_c && left_miss_c) begin
               score_r_d   = sat_inc(score_r_q, WIN_S);
               serve_dir_d = 1'b0;
               state_d     = ST_POINT;
            end else if (eval_c && right_miss_c) begin
               score_l_d   = sat_inc(score_l_q, WIN_S);
               serve_dir_d = 1'b1;
               state_d     = ST_POINT;
            end
         end
         ST_POINT: begin
            if (timer_done_c) begin
               if ((score_l_q == WIN_S) || (score_r_q == WIN_S)) begin
                  state_d  = ST_GAME_OVER;
                  winner_d = (score_l_q == WIN_S) ? WIN_LEFT : WIN_RIGHT;
               end else begin
                  state_d    = ST_SERVE;
                  ball_rst_d = 1'b1;
               end
            end
         end
         ST_GAME_OVER: begin
            if (start_pulse_c) begin
               score_l_d   = '0;
               score_r_d   = '0;
               winner_d    = WIN_NONE;
               serve_dir_d = 1'b0;
               ball_rst_d  = 1'b1;
               state_d     = ST_SERVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // User pause only reaches the ball while play continues.
      if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) ball_pause_d = ctrl_if.pause_sw;
   end

   assign ctrl_if.game_state = state_q;
   assign ctrl_if.score_l    = score_l_q;
   assign ctrl_if.score_r    = score_r_q;
   assign ctrl_if.winner     = winner_q;
   assign ctrl_if.ball_pause = ball_pause_q;
   assign ctrl_if.ball_rst   = ball_rst_q;
   assign ctrl_if.serve_dir  = serve_dir_q;

endmodule

// File: doc/pong_match_controller.md
Name: pong_match_controller

Overview:
- Game-level sequencer for the ball/paddle collision datapath.
- Decides when the ball trajectory unit runs, pauses or re-serves, and detects missed balls at the left/right walls.
- Keeps both players' scores and declares a winner.
- Sits between newFrame detection, the ball trajectory unit (drives its pause/reset) and the VGA draw arbiter (state/score for overlays).

Parameters:
- WALL_LEFT, 0, left playfield column (13-bit).
- WALL_RIGHT, 640, right playfield column, exclusive (13-bit).
- BALL_W, 10, ball width in pixels.
- WIN_SCORE, 7, points needed to win (1..15).
- SERVE_FRAMES, 60, frames ball is held before launch (>=1).
- POINT_FRAMES, 30, frames ball is frozen after a point (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- newFrame  in  1  one-cycle pulse per video frame
- start  in  1  start/restart request, level (button already inverted)
- pause_sw  in  1  user pause switch, level
- ball_x  in  13  ball left-edge column from trajectory unit
- ball_pause  out  1  freeze ball trajectory when 1
- ball_rst  out  1  one-cycle re-centre pulse to trajectory unit
- serve_dir  out  1  0 = serve toward left player, 1 = toward right
- score_l  out  4  left player score
- score_r  out  4  right player score
- game_state  out  3  encoded FSM state for draw overlays
- winner  out  2  00 none, 01 left, 10 right

Behaviour:
- Reset (async, immediate, any state):
  - state IDLE; scores 0; ball_pause 1; ball_rst 0; serve_dir 0; winner 00; frame counter 0; start edge register 0.
- Outputs: all registered.
- start handling:
  - Registered once; start_pulse = start & ~start_q.
  - A held start yields exactly one pulse.
- IDLE:
  - ball_pause 1.
  - On start_pulse: go to SERVE, pulse ball_rst for exactly one clk, clear frame counter.
- SERVE:
  - ball_pause 1.
  - Counter increments on each newFrame.
  - On the newFrame where the count equals SERVE_FRAMES-1: go to PLAY, clear counter.
- PLAY:
  - ball_pause = pause_sw, registered, one-cycle latency.
  - Miss check only on newFrame cycles with pause_sw=0.
  - Left miss: ball_x <= WALL_LEFT. score_r += 1; serve_dir <= 0.
  - Right miss: ball_x + BALL_W >= WALL_RIGHT, computed 14-bit with no overflow. score_l += 1; serve_dir <= 1.
  - Both true: left miss wins. Only one point per frame.
  - After a miss: go to POINT, clear counter.
  - No newFrame means no evaluation, whatever ball_x does mid-frame.
- POINT:
  - ball_pause 1.
  - After POINT_FRAMES newFrames: if either score == WIN_SCORE, go to GAME_OVER; else go to SERVE with a one-clk ball_rst pulse.
- GAME_OVER:
  - ball_pause 1; winner = 01 if score_l == WIN_SCORE, else 10.
  - On start_pulse: clear scores and winner, go to SERVE with ball_rst pulse, serve_dir 0.
- Scores:
  - Saturate at WIN_SCORE; never wrap.
  - Increments never happen outside PLAY.
- start_pulse in SERVE, PLAY or POINT: ignored.
- pause_sw in states other than PLAY: ignored (ball_pause stays 1).
- newFrame and start_pulse in the same cycle in IDLE/GAME_OVER: the transition wins; the counter starts from 0 in SERVE.
- game_state encoding: IDLE 0, SERVE 1, PLAY 2, POINT 3, GAME_OVER 4.

Decomposition:
- Package pong_pkg:
  - game_state encoding localparams.
  - SCORE_W = 4, COORD_W = 13.
  - Winner codes.
- Sub-module frame_timer:
  - Inputs: clk, reset, clear, newFrame, terminal count.
  - Output: done, one-cycle, on the newFrame reaching the count.
  - Instantiated once and shared by SERVE and POINT.

Test Plan (bench params SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=2, WALL_RIGHT=640, BALL_W=10):
- Reset mid-PLAY with score_l=1 -> same cycle: game_state 0, scores 0, ball_pause 1, ball_rst 0.
- start held 20 clks in IDLE -> exactly one ball_rst pulse; game_state 1; PLAY entered on the 3rd newFrame; ball_pause drops to 0 one clk later.
- In PLAY, ball_x=0 and newFrame -> score_r=1, serve_dir 0, state 3. After 2 newFrames -> state 1 with one ball_rst pulse.
- In PLAY, ball_x=630 with no newFrame for 100 clks -> no score. Then newFrame -> score_l=1, serve_dir 1.
- pause_sw=1 in PLAY with ball_x=0 across 5 newFrames -> scores unchanged, ball_pause 1. Release -> point counted on the next newFrame.
- Two right misses -> score_l=2, GAME_OVER, winner 01. Further misses -> no change. start -> scores 0, winner 00, state 1, ball_rst pulse.
